// File: rtl/ysyx_23060077_riscv_mem_arbiter.sv
// Shares one downstream memory port between NR_MASTER requesters, one transaction in flight.
// Round-robin by default; define YSYX_23060077_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
`timescale 1ns/1ps
module ysyx_23060077_riscv_mem_arbiter #(
  parameter int NR_MASTER = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NR_MASTER-1:0]          m_req_valid,
  output logic [NR_MASTER-1:0]          m_req_ready,
  input  logic [NR_MASTER*ADDR_W-1:0]   m_req_addr,
  input  logic [NR_MASTER-1:0]          m_req_wen,
  input  logic [NR_MASTER*DATA_W-1:0]   m_req_wdata,
  input  logic [NR_MASTER*DATA_W/8-1:0] m_req_wmask,
  output logic [NR_MASTER-1:0]          m_resp_valid,
  output logic [DATA_W-1:0]             m_resp_rdata,
  output logic                          s_req_valid,
  input  logic                          s_req_ready,
  output logic [ADDR_W-1:0]             s_req_addr,
  output logic                          s_req_wen,
  output logic [DATA_W-1:0]             s_req_wdata,
  output logic [DATA_W/8-1:0]           s_req_wmask,
  input  logic                          s_resp_valid,
  input  logic [DATA_W-1:0]             s_resp_rdata
);
  localparam int IDX_W  = (NR_MASTER > 1) ? $clog2(NR_MASTER) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0] scan_base;
  logic [IDX_W-1:0] winner;
  logic [IDX_W:0]   scan_sum;
  logic             found;

  logic [ADDR_W-1:0] addr_arr  [NR_MASTER];
  logic [DATA_W-1:0] wdata_arr [NR_MASTER];
  logic [STRB_W-1:0] wmask_arr [NR_MASTER];

  genvar gi;
  generate
    for (gi = 0; gi < NR_MASTER; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_req_addr[ADDR_W*gi +: ADDR_W];
      assign wdata_arr[gi] = m_req_wdata[DATA_W*gi +: DATA_W];
      assign wmask_arr[gi] = m_req_wmask[STRB_W*gi +: STRB_W];
    end
  endgenerate

`ifdef YSYX_23060077_ARB_FIXED_PRIO_EN
  assign scan_base = '0;
`else
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] grant_inc;

  assign grant_inc = (grant_reg == IDX_W'(NR_MASTER - 1)) ? '0 : grant_reg + IDX_W'(1);
  assign scan_base = ptr_reg;

  // Pointer moves past the requester only once its response has come back.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (state_reg == RESP && s_resp_valid) begin
      ptr_reg <= grant_inc;
    end
  end
`endif

  // Scan from scan_base upward, wrapping, and take the first requester found.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_sum = '0;
    for (int i = 0; i < NR_MASTER; i++) begin
      scan_sum = {1'b0, scan_base} + (IDX_W+1)'(i);
      if (scan_sum >= (IDX_W+1)'(NR_MASTER)) begin
        scan_sum = scan_sum - (IDX_W+1)'(NR_MASTER);
      end
      if (!found && m_req_valid[scan_sum[IDX_W-1:0]]) begin
        winner = scan_sum[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    m_req_ready  = '0;
    m_resp_valid = '0;
    m_resp_rdata = '0;
    s_req_valid  = 1'b0;
    s_req_addr   = '0;
    s_req_wen    = 1'b0;
    s_req_wdata  = '0;
    s_req_wmask  = '0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_next = winner;
          state_next = REQ;
        end
      end
      REQ: begin
        s_req_valid            = 1'b1;
        s_req_addr             = addr_arr[grant_reg];
        s_req_wen              = m_req_wen[grant_reg];
        s_req_wdata            = wdata_arr[grant_reg];
        s_req_wmask            = wmask_arr[grant_reg];
        m_req_ready[grant_reg] = s_req_ready;
        if (s_req_ready) begin
          state_next = RESP;
        end
      end
      RESP: begin
        m_resp_valid[grant_reg] = s_resp_valid;
        m_resp_rdata            = s_resp_rdata;
        if (s_resp_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ysyx_23060077_riscv_mem_arbiter.sv
// Vector-table bench for the memory arbiter, with a response scoreboard and hand-written reset/stray-response cases.
`timescale 1ns/1ps
module tb_ysyx_23060077_riscv_mem_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef YSYX_23060077_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [NM-1:0]    m_req_valid;
  logic [NM-1:0]    m_req_ready;
  logic [NM*AW-1:0] m_req_addr;
  logic [NM-1:0]    m_req_wen;
  logic [NM*DW-1:0] m_req_wdata;
  logic [NM*SW-1:0] m_req_wmask;
  logic [NM-1:0]    m_resp_valid;
  logic [DW-1:0]    m_resp_rdata;
  logic             s_req_valid;
  logic             s_req_ready;
  logic [AW-1:0]    s_req_addr;
  logic             s_req_wen;
  logic [DW-1:0]    s_req_wdata;
  logic [SW-1:0]    s_req_wmask;
  logic             s_resp_valid;
  logic [DW-1:0]    s_resp_rdata;

  always #5 clock = ~clock;

  ysyx_23060077_riscv_mem_arbiter #(.NR_MASTER(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wen(m_req_wen), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_rdata(s_resp_rdata)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [1:0]  wen;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [3:0]  wmask0;
    logic [3:0]  wmask1;
    int          stall;
    logic [31:0] rdata;
    int          exp_rr;
    int          exp_fp;
  } vec_t;

  typedef struct {
    int          master;
    logic [31:0] rdata;
  } exp_t;

  vec_t vt [9];
  exp_t sb [$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    m_req_valid  = '0;
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b0;
    s_resp_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Entered in IDLE just after a clock edge; leaves in IDLE just after the closing edge.
  task automatic apply(input vec_t v, input int idx);
    int          g;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wmask;
    logic        e_wen;
    exp_t        e;
    if (v.rst) do_reset();
    g       = FIXED ? v.exp_fp : v.exp_rr;
    e_addr  = (g == 1) ? v.addr1  : v.addr0;
    e_wdata = (g == 1) ? v.wdata1 : v.wdata0;
    e_wmask = (g == 1) ? v.wmask1 : v.wmask0;
    e_wen   = (g == 1) ? v.wen[1] : v.wen[0];
    m_req_valid = v.valid;
    m_req_addr  = {v.addr1, v.addr0};
    m_req_wen   = v.wen;
    m_req_wdata = {v.wdata1, v.wdata0};
    m_req_wmask = {v.wmask1, v.wmask0};
    sb.push_back('{g, v.rdata});
    $display("vec %0d: valid=%b expect grant %0d addr=0x%08h wen=%b", idx, v.valid, g, e_addr, e_wen);
    sample();
    check("idle s_req_valid", 64'(s_req_valid), 64'(0));
    check("idle m_resp_valid", 64'(m_resp_valid), 64'(0));
    tick();
    s_req_ready = (v.stall == 0);
    for (int c = 0; c < v.stall; c++) begin
      sample();
      check("stall s_req_valid", 64'(s_req_valid), 64'(1));
      check("stall s_req_addr", 64'(s_req_addr), 64'(e_addr));
      check("stall m_req_ready", 64'(m_req_ready), 64'(0));
      check("stall m_resp_valid", 64'(m_resp_valid), 64'(0));
      tick();
    end
    s_req_ready = 1'b1;
    sample();
    check("req s_req_valid", 64'(s_req_valid), 64'(1));
    check("req s_req_addr", 64'(s_req_addr), 64'(e_addr));
    check("req s_req_wen", 64'(s_req_wen), 64'(e_wen));
    check("req s_req_wdata", 64'(s_req_wdata), 64'(e_wdata));
    check("req s_req_wmask", 64'(s_req_wmask), 64'(e_wmask));
    check("req m_req_ready", 64'(m_req_ready), 64'(1) << g);
    check("req m_resp_valid", 64'(m_resp_valid), 64'(0));
    tick();
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b1;
    s_resp_rdata = v.rdata;
    sample();
    e = sb.pop_front();
    check("resp m_resp_valid", 64'(m_resp_valid), 64'(1) << e.master);
    check("resp m_resp_rdata", 64'(m_resp_rdata), 64'(e.rdata));
    check("resp s_req_valid", 64'(s_req_valid), 64'(0));
    tick();
    s_resp_valid = 1'b0;
    s_resp_rdata = '0;
  endtask

  initial begin
    vec_t extra;
    //          rst   valid  wen    addr0         addr1         wdata0        wdata1        m0     m1     stall rdata         rr fp
    vt[0] = '{1'b1, 2'b01, 2'b00, 32'h8000_0000, 32'h9000_0004, 32'h0,        32'h0,        4'hF, 4'hF, 0, 32'hDEAD_BEEF, 0, 0};
    vt[1] = '{1'b0, 2'b11, 2'b00, 32'h8000_0100, 32'h9000_0100, 32'h0,        32'h0,        4'hF, 4'hF, 0, 32'h0000_1111, 1, 0};
    vt[2] = '{1'b1, 2'b11, 2'b00, 32'h0000_1000, 32'h0000_2000, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 4'h1, 4'h2, 0, 32'h1111_0000, 0, 0};
    vt[3] = '{1'b0, 2'b11, 2'b00, 32'h0000_1004, 32'h0000_2004, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 4'h1, 4'h2, 0, 32'h2222_0000, 1, 0};
    vt[4] = '{1'b0, 2'b11, 2'b00, 32'h0000_1008, 32'h0000_2008, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 4'h1, 4'h2, 0, 32'h3333_0000, 0, 0};
    vt[5] = '{1'b0, 2'b11, 2'b00, 32'h0000_100C, 32'h0000_200C, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 4'h1, 4'h2, 0, 32'h4444_0000, 1, 0};
    vt[6] = '{1'b0, 2'b10, 2'b10, 32'h7000_0000, 32'h8000_0010, 32'hCAFE_F00D, 32'h1234_5678, 4'hF, 4'h3, 0, 32'h55AA_55AA, 1, 1};
    vt[7] = '{1'b0, 2'b01, 2'b10, 32'h8000_0040, 32'h9000_0040, 32'h0,        32'h7777_7777, 4'hF, 4'hC, 5, 32'h6666_7777, 0, 0};
    vt[8] = '{1'b0, 2'b11, 2'b00, 32'h8000_0080, 32'h9000_0080, 32'h0,        32'h0,        4'hF, 4'hF, 0, 32'h7777_8888, 1, 0};

    reset        = 1'b1;
    m_req_valid  = '0;
    m_req_addr   = '0;
    m_req_wen    = '0;
    m_req_wdata  = '0;
    m_req_wmask  = '0;
    s_req_ready  = 1'b1;
    s_resp_valid = 1'b1;
    s_resp_rdata = 32'hFFFF_FFFF;
    tick();
    sample();
    $display("reset: checking idle outputs");
    check("rst s_req_valid", 64'(s_req_valid), 64'(0));
    check("rst m_req_ready", 64'(m_req_ready), 64'(0));
    check("rst m_resp_valid", 64'(m_resp_valid), 64'(0));
    check("rst m_resp_rdata", 64'(m_resp_rdata), 64'(0));
    check("rst s_req_addr", 64'(s_req_addr), 64'(0));
    check("rst s_req_wdata", 64'(s_req_wdata), 64'(0));
    tick();
    reset        = 1'b0;
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b0;
    s_resp_rdata = '0;

    for (int i = 0; i < 9; i++) apply(vt[i], i);

    // Abort in RESP: finish a master-0 transaction first so the pointer is non-zero.
    do_reset();
    extra = '{1'b0, 2'b01, 2'b00, 32'h8000_0200, 32'h9000_0200, 32'h0, 32'h0, 4'hF, 4'hF, 0, 32'h1357_9BDF, 0, 0};
    apply(extra, 9);
    m_req_valid = 2'b10;
    m_req_addr  = {32'h9000_0300, 32'h8000_0300};
    tick();
    s_req_ready = 1'b1;
    tick();
    s_req_ready = 1'b0;
    reset       = 1'b1;
    m_req_valid = '0;
    $display("abort: reset asserted in RESP");
    sample();
    check("abort resp held", 64'(m_resp_valid), 64'(0));
    tick();
    s_resp_valid = 1'b1;
    s_resp_rdata = 32'h0BAD_0BAD;
    sample();
    check("abort s_req_valid", 64'(s_req_valid), 64'(0));
    check("abort m_req_ready", 64'(m_req_ready), 64'(0));
    check("abort m_resp_valid", 64'(m_resp_valid), 64'(0));
    check("abort m_resp_rdata", 64'(m_resp_rdata), 64'(0));
    check("abort s_req_addr", 64'(s_req_addr), 64'(0));
    tick();
    reset = 1'b0;
    $display("stray: s_resp_valid pulsed in IDLE");
    sample();
    check("stray m_resp_valid", 64'(m_resp_valid), 64'(0));
    check("stray m_resp_rdata", 64'(m_resp_rdata), 64'(0));
    check("stray s_req_valid", 64'(s_req_valid), 64'(0));
    tick();
    s_resp_valid = 1'b0;
    s_resp_rdata = '0;
    // Pointer must be back at 0 after the abort.
    extra = '{1'b0, 2'b11, 2'b00, 32'h8000_0400, 32'h9000_0400, 32'h0, 32'h0, 4'hF, 4'hF, 0, 32'h2468_ACE0, 0, 0};
    apply(extra, 10);

    m_req_valid = '0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/ysyx_23060077_riscv_mem_arbiter.md
Name: ysyx_23060077_riscv_mem_arbiter

Overview:
- Round-robin arbiter that shares one downstream memory port between NR_MASTER requesters, e.g. IFU fetch and LSU load/store onto the single core bus master.
- Request fields of the granted requester are key-selected onto the downstream port.
- Response is routed back to the granted requester only.
- The grant is locked for one full request/response transaction; there is one outstanding transaction at a time.

Parameters:
- NR_MASTER, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; a multiple of 8.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- m_req_valid  input  NR_MASTER  per-requester request valid.
- m_req_ready  output  NR_MASTER  per-requester request accepted.
- m_req_addr  input  NR_MASTER*ADDR_W  packed addresses; requester n occupies bits [ADDR_W*(n+1)-1 : ADDR_W*n].
- m_req_wen  input  NR_MASTER  write enable per requester.
- m_req_wdata  input  NR_MASTER*DATA_W  packed write data.
- m_req_wmask  input  NR_MASTER*DATA_W/8  packed byte strobes.
- m_resp_valid  output  NR_MASTER  per-requester response valid, one-cycle pulse.
- m_resp_rdata  output  DATA_W  read data, broadcast to all requesters; qualified by m_resp_valid.
- s_req_valid  output  1  downstream request valid.
- s_req_ready  input  1  downstream request accepted.
- s_req_addr  output  ADDR_W  granted address.
- s_req_wen  output  1  granted write enable.
- s_req_wdata  output  DATA_W  granted write data.
- s_req_wmask  output  DATA_W/8  granted strobes.
- s_resp_valid  input  1  downstream response valid.
- s_resp_rdata  input  DATA_W  downstream read data.

Behaviour:
- The FSM has three states: IDLE, REQ, RESP.
- Reset:
  - state=IDLE, grant index g=0, rr pointer p=0.
  - s_req_valid=0; m_req_ready=0; m_resp_valid=0.
  - s_req_addr, s_req_wen, s_req_wdata, s_req_wmask and m_resp_rdata drive 0.
  - Reset asserted mid-transaction aborts it immediately; the next state is IDLE and no response pulse is produced.
- IDLE:
  - If any m_req_valid bit is set, the winner is the first set bit found scanning from index p upward, wrapping modulo NR_MASTER.
  - The winner is registered into g and the next state is REQ.
  - All outputs are inactive in IDLE.
- REQ:
  - s_req_valid=1.
  - s_req_* are combinationally selected from requester g's fields.
  - m_req_ready[g]=s_req_ready; all other m_req_ready bits are 0.
  - When s_req_valid && s_req_ready, the next state is RESP.
  - Requesters hold valid and their fields stable until ready, as a protocol rule. The arbiter does not re-arbitrate in REQ.
- RESP:
  - m_resp_valid[g]=s_resp_valid; m_resp_rdata=s_resp_rdata. Other m_resp_valid bits are 0.
  - On s_resp_valid, the next state is IDLE and p=(g+1) mod NR_MASTER.
- Latency: minimum 3 cycles from m_req_valid rising to the requester seeing m_resp_valid (IDLE→REQ, REQ→RESP, response in RESP), given zero downstream wait.
- There is no back-to-back bypass; IDLE is always visited between transactions.
- Simultaneous requests in the same IDLE cycle resolve by rr order only.
- A requester that loses keeps m_req_valid asserted. It is guaranteed service within NR_MASTER-1 transactions.
- s_resp_valid in IDLE or REQ is ignored and not forwarded.
- s_req_ready outside REQ is ignored.
- Writes also wait for s_resp_valid, which serves as the write acknowledge. m_resp_rdata is don't-care for writes.

Optional Feature:
- Macro: YSYX_23060077_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest set index of m_req_valid wins. p is not updated and is tied to 0.
- Undefined: round-robin as above.
- Handshake, FSM and latency are identical in both modes.

Test Plan:
- Single request, NR_MASTER=2:
  - Stimulus: m_req_valid=2'b01, addr0=0x8000_0000, read, s_req_ready=1 always, s_resp_valid one cycle after the handshake with rdata=0xDEAD_BEEF.
  - Required response: s_req_addr=0x8000_0000 in REQ; m_resp_valid=2'b01 with m_resp_rdata=0xDEAD_BEEF exactly 3 cycles after valid rises; p=1 afterwards.
- Contention round-robin:
  - Stimulus: both requesters hold valid for 4 transactions from reset.
  - Required response: grants in order 0,1,0,1; m_resp_valid never asserts for the non-granted requester.
- Downstream backpressure:
  - Stimulus: s_req_ready low for 5 cycles in REQ.
  - Required response: s_req_valid stays 1, fields stay stable, m_req_ready[g]=0 until ready, then the FSM moves to RESP.
- Write path:
  - Stimulus: requester 1 writes addr=0x8000_0010, wdata=0x1234_5678, wmask=4'b0011.
  - Required response: s_req_wen=1 and s_req_wmask=4'b0011 in REQ; response pulse on m_resp_valid[1] only.
- Reset mid-transaction and stray response:
  - Stimulus: reset asserted in RESP; separately, s_resp_valid pulsed in IDLE.
  - Required response: state=IDLE, all outputs 0, p=0; no m_resp_valid pulse in either case.
- Fixed-priority build:
  - Stimulus: YSYX_23060077_ARB_FIXED_PRIO_EN defined, both requesters valid for 3 transactions.
  - Required response: all 3 grants go to requester 0.
